pipelined_multiplier: RTL and testbench

//  Pipelined unsigned shift-and-add multiplier; the inverse datapath of the divider.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_step.sv | 19 +
 rtl/pipelined_multiplier.sv | 86 ++++++++
 tb/tb_pipelined_multiplier.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared rank type and rank-count helper for the pipelined multiplier
package mult_pkg;

  localparam int W   = 14;
  localparam int BPS = 2;

  // One pipeline rank: qualifier, running sum, and the operands still being retired
  typedef struct packed {
    logic             valid;
    logic [2*W-1:0]   acc;
    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
  } mult_rank_t;

  // Number of register ranks needed to retire all multiplier bits
  function automatic int ranks(input int w, input int bps);
    return w / bps;
  endfunction

endpackage

// File: rtl/mult_step.sv
// rtl/mult_step.sv - one combinational shift-and-add step of the multiplier
module mult_step #(
  parameter int WIDTH = 14,
  parameter int IDXW  = 4
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  input  logic [IDXW-1:0]    bit_idx,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [2*WIDTH-1:0] w_shifted;

  // Multiplicand is widened before shifting so no partial product bits are lost
  assign w_shifted = {{WIDTH{1'b0}}, mcand_in} << bit_idx;
  assign acc_out   = mplier_in[bit_idx] ? (acc_in + w_shifted) : acc_in;

endmodule

// File: rtl/pipelined_multiplier.sv
// rtl/pipelined_multiplier.sv - pipelined unsigned shift-and-add multiplier; optional addend via MULT_ADDEND_EN
module pipelined_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH          = W,
  parameter int BITS_PER_STAGE = BPS
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplier_in,
  input  logic                 data_valid_in,
  input  logic                 pause,
`ifdef MULT_ADDEND_EN
  input  logic [WIDTH-1:0]     addend_in,
`endif
  output logic [2*WIDTH-1:0]   product_out,
  output logic                 data_valid_out
);

  localparam int L    = ranks(WIDTH, BITS_PER_STAGE);
  localparam int IDXW = $clog2(WIDTH);

  // The rank type is sized by the package, so the operand width must agree with it
  if (WIDTH % BITS_PER_STAGE != 0) begin : g_bad_bps
    $error("WIDTH must be a multiple of BITS_PER_STAGE");
  end
  if (WIDTH != W) begin : g_bad_width
    $error("WIDTH must match mult_pkg::W");
  end

  mult_rank_t r_rank [L];
  mult_rank_t w_next [L];
  logic [2*WIDTH-1:0] w_init_acc;

`ifdef MULT_ADDEND_EN
  assign w_init_acc = {{WIDTH{1'b0}}, addend_in};
`else
  assign w_init_acc = '0;
`endif

  for (genvar i = 0; i < L; i++) begin : g_rank
    mult_rank_t         w_src;
    logic [2*WIDTH-1:0] w_acc [BITS_PER_STAGE+1];

    if (i == 0) begin : g_first
      assign w_src = {data_valid_in, w_init_acc, multiplicand_in, multiplier_in};
    end else begin : g_later
      assign w_src = r_rank[i-1];
    end

    assign w_acc[0] = w_src.acc;

    for (genvar j = 0; j < BITS_PER_STAGE; j++) begin : g_step
      mult_step #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
      ) u_step (
        .acc_in    (w_acc[j]),
        .mcand_in  (w_src.mcand),
        .mplier_in (w_src.mplier),
        .bit_idx   (IDXW'(i * BITS_PER_STAGE + j)),
        .acc_out   (w_acc[j+1])
      );
    end

    assign w_next[i] = {w_src.valid, w_acc[BITS_PER_STAGE], w_src.mcand, w_src.mplier};
  end

  // Advance every rank together; reset flushes in-flight ops, pause freezes the whole pipe
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < L; k++) begin
        r_rank[k] <= '0;
      end
    end else if (!pause) begin
      for (int k = 0; k < L; k++) begin
        r_rank[k] <= w_next[k];
      end
    end
  end

  assign product_out    = r_rank[L-1].acc;
  assign data_valid_out = r_rank[L-1].valid;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// tb/tb_pipelined_multiplier.sv - directed self-checking bench for pipelined_multiplier
module tb_pipelined_multiplier;

  localparam int WD = 14;
  localparam int L  = 7;

  logic              clk_in;
  logic              rst_in;
  logic [WD-1:0]     multiplicand_in;
  logic [WD-1:0]     multiplier_in;
  logic              data_valid_in;
  logic              pause;
`ifdef MULT_ADDEND_EN
  logic [WD-1:0]     addend_in;
`endif
  logic [2*WD-1:0]   product_out;
  logic              data_valid_out;

  int total;
  int bad;

  pipelined_multiplier dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .multiplicand_in (multiplicand_in),
    .multiplier_in   (multiplier_in),
    .data_valid_in   (data_valid_in),
    .pause           (pause),
`ifdef MULT_ADDEND_EN
    .addend_in       (addend_in),
`endif
    .product_out     (product_out),
    .data_valid_out  (data_valid_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WD-1:0] a, input logic [WD-1:0] b);
    data_valid_in   = v;
    multiplicand_in = a;
    multiplier_in   = b;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    pause  = 1'b0;
    drive(1'b1, 14'd5, 14'd5);
    for (int e = 0; e < 2; e++) begin
      step();
      total++;
      if (data_valid_out !== 1'b0 || product_out !== '0) begin
        bad++;
        $display("FAIL reset_hold e=%0d got valid=%b prod=%0d want valid=0 prod=0", e, data_valid_out, product_out);
      end
    end
    rst_in = 1'b0;
    for (int e = 0; e < L + 1; e++) begin
      logic            exp_v;
      logic [2*WD-1:0] exp_p;
      if (e == 1) drive(1'b0, 14'd0, 14'd0);
      step();
      exp_v = (e == L - 1);
      exp_p = exp_v ? 28'd25 : 28'd0;
      total++;
      if (data_valid_out !== exp_v || product_out !== exp_p) begin
        bad++;
        $display("FAIL reset_release e=%0d got valid=%b prod=%0d want valid=%b prod=%0d", e, data_valid_out, product_out, exp_v, exp_p);
      end
    end
  endtask

  task automatic test_single();
    for (int e = 0; e < 10; e++) begin
      logic exp_v;
      if (e == 0) drive(1'b1, 14'd100, 14'd37);
      else        drive(1'b0, 14'd0, 14'd0);
      step();
      exp_v = (e == 6);
      total++;
      if (data_valid_out !== exp_v || (exp_v && product_out !== 28'd3700)) begin
        bad++;
        $display("FAIL single e=%0d got valid=%b prod=%0d want valid=%b prod=3700", e, data_valid_out, product_out, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int e = 0; e < 12; e++) begin
      logic            exp_v;
      logic [2*WD-1:0] exp_p;
      case (e)
        0:       drive(1'b1, 14'd16383, 14'd16383);
        1:       drive(1'b1, 14'd0, 14'd5);
        2:       drive(1'b1, 14'd1, 14'd16383);
        default: drive(1'b0, 14'd0, 14'd0);
      endcase
      step();
      exp_v = (e >= 6 && e <= 8);
      case (e)
        6:       exp_p = 28'd268402689;
        7:       exp_p = 28'd0;
        8:       exp_p = 28'd16383;
        default: exp_p = 28'd0;
      endcase
      total++;
      if (data_valid_out !== exp_v || (exp_v && product_out !== exp_p)) begin
        bad++;
        $display("FAIL b2b e=%0d got valid=%b prod=%0d want valid=%b prod=%0d", e, data_valid_out, product_out, exp_v, exp_p);
      end
    end
  endtask

  task automatic test_pause();
    for (int e = 0; e < 13; e++) begin
      logic exp_v;
      pause = (e >= 2 && e <= 4) || (e == 10);
      if (e == 0)                drive(1'b1, 14'd123, 14'd45);
      else if (e >= 2 && e <= 4) drive(1'b1, 14'd7, 14'd7);
      else                       drive(1'b0, 14'd0, 14'd0);
      step();
      exp_v = (e == 9) || (e == 10);
      total++;
      if (data_valid_out !== exp_v || (exp_v && product_out !== 28'd5535)) begin
        bad++;
        $display("FAIL pause e=%0d got valid=%b prod=%0d want valid=%b prod=5535", e, data_valid_out, product_out, exp_v);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_reset_flush();
    for (int e = 0; e < 13; e++) begin
      rst_in = (e == 3);
      if (e <= 2) drive(1'b1, 14'd50 + 14'(e), 14'd3);
      else        drive(1'b0, 14'd0, 14'd0);
      step();
      total++;
      if (data_valid_out !== 1'b0) begin
        bad++;
        $display("FAIL flush e=%0d got valid=%b want valid=0", e, data_valid_out);
      end
    end
    rst_in = 1'b0;
    for (int e = 0; e < 9; e++) begin
      logic exp_v;
      if (e == 0) drive(1'b1, 14'd3, 14'd4);
      else        drive(1'b0, 14'd0, 14'd0);
      step();
      exp_v = (e == 6);
      total++;
      if (data_valid_out !== exp_v || (exp_v && product_out !== 28'd12)) begin
        bad++;
        $display("FAIL after_flush e=%0d got valid=%b prod=%0d want valid=%b prod=12", e, data_valid_out, product_out, exp_v);
      end
    end
  endtask

`ifdef MULT_ADDEND_EN
  task automatic test_addend();
    for (int e = 0; e < 10; e++) begin
      logic            exp_v;
      logic [2*WD-1:0] exp_p;
      case (e)
        0: begin drive(1'b1, 14'd9, 14'd1000);        addend_in = 14'd7;     end
        1: begin drive(1'b1, 14'd16383, 14'd16383);   addend_in = 14'd16383; end
        default: begin drive(1'b0, 14'd0, 14'd0);     addend_in = 14'd0;     end
      endcase
      step();
      exp_v = (e == 6) || (e == 7);
      exp_p = (e == 6) ? 28'd9007 : 28'd268419072;
      total++;
      if (data_valid_out !== exp_v || (exp_v && product_out !== exp_p)) begin
        bad++;
        $display("FAIL addend e=%0d got valid=%b prod=%0d want valid=%b prod=%0d", e, data_valid_out, product_out, exp_v, exp_p);
      end
    end
  endtask
`endif

  initial begin
    total  = 0;
    bad    = 0;
    rst_in = 1'b1;
    pause  = 1'b0;
    drive(1'b0, 14'd0, 14'd0);
`ifdef MULT_ADDEND_EN
    addend_in = 14'd0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_pause();
    test_reset_flush();
`ifdef MULT_ADDEND_EN
    test_addend();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
